// File: rtl/fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit_if                                              |
// | Description : Bundle of the fetch stage's external handshakes:           |
// |               instruction-memory req/gnt/rvalid bus, control-flow        |
// |               redirect, and the valid/ready output towards decode.       |
// |               master = fetch unit side, slave = memory/decode side.      |
// | Signals     : imem_req, imem_addr[31:0]  (fetch -> memory)               |
// |               imem_gnt, imem_rvalid, imem_rdata[31:0] (memory -> fetch)  |
// |               redirect, redirect_pc[31:0] (execute -> fetch)             |
// |               id_valid, id_instr, id_pc, id_pc_plus4 (fetch -> decode)   |
// |               id_ready (decode -> fetch)                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output id_valid, id_instr, id_pc, id_pc_plus4,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  id_valid, id_instr, id_pc, id_pc_plus4,
    output id_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit                                                 |
// | Description : Instruction fetch stage. Owns the fetch PC, issues word    |
// |               reads over req/gnt/rvalid, buffers returned words with     |
// |               their PCs and presents {instr, pc, pc+4} to decode.        |
// |               A redirect restarts fetch and drops buffered and           |
// |               in-flight words.                                           |
// | Ports       : clk    - clock, rising edge                                |
// |               rst_n  - asynchronous active-low reset                     |
// |               bus    - fetch_unit_if.master (imem bus, redirect, decode) |
// | Parameters  : RESET_PC   - first fetch address (word aligned)            |
// |               FIFO_DEPTH - buffer entries = cap on outstanding+buffered  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int              c_CW    = $clog2(FIFO_DEPTH + 1);
  localparam int              c_PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_CW:0]   c_DEPTH = FIFO_DEPTH[c_CW:0];
  localparam logic [31:0]     c_NOP   = 32'h0000_0013;

  logic [31:0]     r_fetch_pc;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_discard;
  logic [c_CW-1:0] r_count;
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_PW-1:0] r_pcq_wptr;
  logic [c_PW-1:0] r_pcq_rptr;
  logic [31:0]     r_fifo_instr [FIFO_DEPTH];
  logic [31:0]     r_fifo_pc    [FIFO_DEPTH];
  // PCs of granted-but-unreturned requests, in issue order. Discarded
  // responses still pop this queue so it stays aligned with the bus.
  logic [31:0]     r_pcq        [FIFO_DEPTH];

  logic [c_CW:0]   w_inflight;
  logic            w_req;
  logic            w_grant;
  logic            w_resp;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(FIFO_DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  // Credit: every granted request is guaranteed a FIFO slot on return.
  // rst_n gates the request so it is low while reset is asserted and rises
  // in the first cycle after release.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_req      = rst_n && !bus.redirect && (w_inflight < c_DEPTH);
  assign w_grant    = w_req && bus.imem_gnt;
  assign w_resp     = bus.imem_rvalid;
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && bus.id_ready;
  assign w_push     = w_resp && (r_discard == '0) && !bus.redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_pcq_wptr    <= '0;
      r_pcq_rptr    <= '0;
    end else begin
      r_outstanding <= r_outstanding + c_CW'(w_grant) - c_CW'(w_resp);
      if (w_grant) r_pcq_wptr <= f_inc(r_pcq_wptr);
      if (w_resp)  r_pcq_rptr <= f_inc(r_pcq_rptr);
      if (bus.redirect) begin
        r_fetch_pc <= bus.redirect_pc & ~32'h3;
        // Everything still on the bus after this cycle's return belongs to
        // the old path (no grant can happen in a redirect cycle).
        r_discard  <= r_outstanding - c_CW'(w_resp);
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp && (r_discard != '0)) r_discard <= r_discard - c_CW'(1);
        if (w_push) r_wptr <= f_inc(r_wptr);
        if (w_pop)  r_rptr <= f_inc(r_rptr);
        r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
      end
    end
  end

  // Storage arrays need no reset: their contents are only observed through
  // w_valid, which is reset.
  always_ff @(posedge clk) begin
    if (w_grant) r_pcq[r_pcq_wptr] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_instr[r_wptr] <= bus.imem_rdata;
      r_fifo_pc[r_wptr]    <= r_pcq[r_pcq_rptr];
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.id_valid    = w_valid;
  assign bus.id_instr    = w_valid ? r_fifo_instr[r_rptr] : c_NOP;
  assign bus.id_pc       = w_valid ? r_fifo_pc[r_rptr]    : RESET_PC;
  assign bus.id_pc_plus4 = bus.id_pc + 32'd4;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rvalid |-> (r_outstanding != '0));

endmodule
`default_nettype wire
